// File: rtl/uart_host_fifo.sv
// uart_host_fifo: host-side byte engine for the UART transceiver parallel interface.
// A TX FIFO feeds the transceiver one byte at a time (xcvr_tx_wr / xcvr_tx_done handshake).
// An RX FIFO captures received bytes and keeps sticky overrun/break flags.
// Optional feature macro: UART_HOST_TIMEOUT_EN adds a WAIT-state watchdog that abandons a
// byte after TX_TIMEOUT cycles without xcvr_tx_done and raises the sticky tx_timeout flag.
module uart_host_fifo #(
    parameter int DEPTH_LOG2 = 4,
    parameter int TX_TIMEOUT = 200000
) (
    input  logic                  sys_clk,
    input  logic                  sys_rst_n,
    input  logic                  tx_push,
    input  logic [7:0]            tx_push_data,
    output logic                  tx_full,
    output logic [DEPTH_LOG2:0]   tx_level,
    input  logic                  rx_pop,
    output logic [7:0]            rx_pop_data,
    output logic                  rx_empty,
    output logic [DEPTH_LOG2:0]   rx_level,
    output logic                  rx_overrun,
    output logic                  rx_break_seen,
    output logic                  tx_timeout,
    input  logic                  err_clr,
    output logic [7:0]            xcvr_tx_data,
    output logic                  xcvr_tx_wr,
    input  logic                  xcvr_tx_done,
    input  logic [7:0]            xcvr_rx_data,
    input  logic                  xcvr_rx_done,
    input  logic                  xcvr_rx_break
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] LVL_FULL = (DEPTH_LOG2 + 1)'(DEPTH);

    typedef enum logic {
        S_IDLE,
        S_WAIT
    } tx_state_t;

    tx_state_t state, state_nxt;
    logic      wr_nxt;

    // TX FIFO state
    logic [7:0]            tx_mem [DEPTH];
    logic [DEPTH_LOG2-1:0] tx_wptr, tx_rptr;
    logic [DEPTH_LOG2:0]   tx_cnt;
    logic                  tx_pop_en, tx_push_en;

    // RX FIFO state
    logic [7:0]            rx_mem [DEPTH];
    logic [DEPTH_LOG2-1:0] rx_wptr, rx_rptr;
    logic [DEPTH_LOG2:0]   rx_cnt;
    logic                  rx_full;
    logic                  rx_pop_en, rx_push_en, rx_ovr_set;

    // The engine pops the TX head in the same cycle it decides to issue it, so a push
    // into a full FIFO still lands when that pop frees the slot.
    assign tx_full    = (tx_cnt == LVL_FULL);
    assign tx_level   = tx_cnt;
    assign tx_pop_en  = wr_nxt;
    assign tx_push_en = tx_push && (!tx_full || tx_pop_en);

    assign rx_full     = (rx_cnt == LVL_FULL);
    assign rx_empty    = (rx_cnt == '0);
    assign rx_level    = rx_cnt;
    assign rx_pop_data = rx_mem[rx_rptr];
    assign rx_pop_en   = rx_pop && !rx_empty;
    assign rx_push_en  = xcvr_rx_done && (!rx_full || rx_pop_en);
    assign rx_ovr_set  = xcvr_rx_done && rx_full && !rx_pop_en;

`ifdef UART_HOST_TIMEOUT_EN
    localparam int CNT_W = (TX_TIMEOUT > 2) ? $clog2(TX_TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TX_TIMEOUT - 1);

    logic [CNT_W-1:0] wait_cnt;
    logic             timeout_hit;
    logic             tx_timeout_q;

    // Count cycles spent in WAIT; any IDLE cycle rearms the count for the next byte
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            wait_cnt <= '0;
        end else if (state != S_WAIT) begin
            wait_cnt <= '0;
        end else begin
            wait_cnt <= wait_cnt + 1'b1;
        end
    end

    // Sticky timeout flag; a new timeout beats a simultaneous clear
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            tx_timeout_q <= 1'b0;
        end else if (timeout_hit) begin
            tx_timeout_q <= 1'b1;
        end else if (err_clr) begin
            tx_timeout_q <= 1'b0;
        end
    end

    assign tx_timeout = tx_timeout_q;
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = (TX_TIMEOUT == 0);
    assign tx_timeout = 1'b0;
`endif

    // TX FSM state register
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // TX FSM next state and issue decision
    always_comb begin
        state_nxt = state;
        wr_nxt    = 1'b0;
`ifdef UART_HOST_TIMEOUT_EN
        timeout_hit = 1'b0;
`endif
        case (state)
            S_IDLE: begin
                if (tx_cnt != '0) begin
                    wr_nxt    = 1'b1;
                    state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                if (xcvr_tx_done) begin
                    state_nxt = S_IDLE;
                end
`ifdef UART_HOST_TIMEOUT_EN
                else if (wait_cnt == CNT_LAST) begin
                    timeout_hit = 1'b1;
                    state_nxt   = S_IDLE;
                end
`endif
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Registered transceiver outputs: one-cycle start pulse with the byte held afterwards
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            xcvr_tx_wr   <= 1'b0;
            xcvr_tx_data <= 8'h00;
        end else begin
            xcvr_tx_wr <= wr_nxt;
            if (wr_nxt) begin
                xcvr_tx_data <= tx_mem[tx_rptr];
            end
        end
    end

    // TX pointers and occupancy
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            tx_wptr <= '0;
            tx_rptr <= '0;
            tx_cnt  <= '0;
        end else begin
            if (tx_push_en) tx_wptr <= tx_wptr + 1'b1;
            if (tx_pop_en)  tx_rptr <= tx_rptr + 1'b1;
            case ({tx_push_en, tx_pop_en})
                2'b10:   tx_cnt <= tx_cnt + 1'b1;
                2'b01:   tx_cnt <= tx_cnt - 1'b1;
                default: tx_cnt <= tx_cnt;
            endcase
        end
    end

    // TX storage; a write into the slot being issued reads the old byte at the same edge
    always_ff @(posedge sys_clk) begin
        if (tx_push_en) tx_mem[tx_wptr] <= tx_push_data;
    end

    // RX pointers and occupancy
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            rx_wptr <= '0;
            rx_rptr <= '0;
            rx_cnt  <= '0;
        end else begin
            if (rx_push_en) rx_wptr <= rx_wptr + 1'b1;
            if (rx_pop_en)  rx_rptr <= rx_rptr + 1'b1;
            case ({rx_push_en, rx_pop_en})
                2'b10:   rx_cnt <= rx_cnt + 1'b1;
                2'b01:   rx_cnt <= rx_cnt - 1'b1;
                default: rx_cnt <= rx_cnt;
            endcase
        end
    end

    // RX storage
    always_ff @(posedge sys_clk) begin
        if (rx_push_en) rx_mem[rx_wptr] <= xcvr_rx_data;
    end

    // Sticky RX flags; a new event beats a simultaneous clear
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            rx_overrun    <= 1'b0;
            rx_break_seen <= 1'b0;
        end else begin
            if (rx_ovr_set)   rx_overrun <= 1'b1;
            else if (err_clr) rx_overrun <= 1'b0;
            if (xcvr_rx_break) rx_break_seen <= 1'b1;
            else if (err_clr)  rx_break_seen <= 1'b0;
        end
    end

endmodule
